// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and default geometry for the TinyChip data
//               memory. Holds the controller state encoding and the default
//               word width / address width used by the core.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Controller states: CLEAR fills the array, IDLE accepts requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_t;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 6;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : Plain storage array of 2**AW words of DW bits. One
//               synchronous write port, one asynchronous read port. Contents
//               are never reset.
// Ports       : clk      - clock
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               raddr_i  - read address
//               rdata_o  - read data (combinational from raddr_i)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_param
// Description : Parametrised single-port data memory. Registered reads with a
//               one-cycle read_valid pulse, write-first forwarding when a read
//               and a write hit in the same cycle, and an optional post-reset
//               clear pass that fills every word with CLEAR_VAL while ready
//               is held low.
// Ports       : clk        - clock, all state updates on rising edge
//               reset      - synchronous active-high reset
//               addr       - word address for read and write
//               write_data - data to store
//               mem_read   - read request (accepted only while ready)
//               mem_write  - write request (accepted only while ready)
//               read_data  - registered read result, holds between reads
//               read_valid - high for one cycle after an accepted read
//               ready      - high when requests are accepted
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_param
    import data_mem_pkg::*;
#(
    parameter int            DW             = DEF_DW,
    parameter int            AW             = DEF_AW,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] CLEAR_VAL      = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] write_data,
    input  logic          mem_read,
    input  logic          mem_write,
    output logic [DW-1:0] read_data,
    output logic          read_valid,
    output logic          ready
);

    localparam mem_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [AW-1:0] LAST_PTR = '1;

    mem_state_t    state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;

    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_mem_rdata;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            clr_ptr_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: clear sequencer and read path
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;

        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (mem_read) begin
                    read_valid_d = 1'b1;
                    // Single port: a simultaneous write always targets the
                    // read address, so forward the incoming data.
                    read_data_d  = mem_write ? write_data : w_mem_rdata;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write-port mux: clear sequencer owns the port while clearing.
    // Writes are suppressed in a reset cycle so user requests arriving with
    // reset cannot disturb memory contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = addr;
        w_mem_wdata = write_data;
        if (!reset) begin
            if (state_q == CLEAR) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = clr_ptr_q;
                w_mem_wdata = CLEAR_VAL;
            end else begin
                w_mem_we    = mem_write;
            end
        end
    end

    data_mem_array #(
        .DW (DW),
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (w_mem_we),
        .waddr_i (w_mem_waddr),
        .wdata_i (w_mem_wdata),
        .raddr_i (addr),
        .rdata_o (w_mem_rdata)
    );

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign ready      = (state_q == IDLE);

endmodule : data_memory_param
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_param
// Description : Self-checking bench for data_memory_param. Instance A uses
//               the default geometry with clear-on-reset; instance B uses
//               DW=8, AW=3 with the clear pass disabled. Inputs change on the
//               falling edge, outputs are checked on the following falling
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        reset_a;
    logic [5:0]  addr_a;
    logic [15:0] wd_a;
    logic        rd_a, wr_a;
    logic [15:0] rdata_a;
    logic        rvalid_a, ready_a;

    // Instance B: DW=8, AW=3, no clear
    logic        reset_b;
    logic [2:0]  addr_b;
    logic [7:0]  wd_b;
    logic        rd_b, wr_b;
    logic [7:0]  rdata_b;
    logic        rvalid_b, ready_b;

    data_memory_param dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .addr       (addr_a),
        .write_data (wd_a),
        .mem_read   (rd_a),
        .mem_write  (wr_a),
        .read_data  (rdata_a),
        .read_valid (rvalid_a),
        .ready      (ready_a)
    );

    data_memory_param #(
        .DW             (8),
        .AW             (3),
        .CLEAR_ON_RESET (0),
        .CLEAR_VAL      (8'h00)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .addr       (addr_b),
        .write_data (wd_b),
        .mem_read   (rd_b),
        .mem_write  (wr_b),
        .read_data  (rdata_b),
        .read_valid (rvalid_b),
        .ready      (ready_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One rising edge, returning at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_a();
        addr_a = '0; wd_a = '0; rd_a = 1'b0; wr_a = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    function automatic vec_t mk(logic [5:0] a, logic [15:0] d, logic r, logic w,
                                logic ev, logic [15:0] ed);
        vec_t v;
        v.addr = a; v.wdata = d; v.rd = r; v.wr = w;
        v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    // Counts rising edges until ready_a goes high; flags any read_valid.
    task automatic count_clear(output int cycles, output int saw_valid);
        cycles = 0;
        saw_valid = 0;
        while (!ready_a && cycles < 200) begin
            cycle();
            cycles++;
            if (rvalid_a) saw_valid = 1;
        end
    endtask

    initial begin
        vec_t vq[$];
        int   ncyc;
        int   sv;

        vq.push_back(mk(6'd0,  16'h0000, 1, 0, 1, 16'h0000));
        vq.push_back(mk(6'd31, 16'h0000, 1, 0, 1, 16'h0000));
        vq.push_back(mk(6'd63, 16'h0000, 1, 0, 1, 16'h0000));
        vq.push_back(mk(6'd3,  16'h0000, 1, 0, 1, 16'h0000)); // write during clear was dropped
        vq.push_back(mk(6'd0,  16'h0000, 0, 0, 0, 16'h0000));
        vq.push_back(mk(6'd5,  16'hBEEF, 0, 1, 0, 16'h0000));
        vq.push_back(mk(6'd5,  16'h0000, 1, 0, 1, 16'hBEEF));
        vq.push_back(mk(6'd0,  16'h0000, 0, 0, 0, 16'hBEEF));
        vq.push_back(mk(6'd9,  16'h1111, 0, 1, 0, 16'hBEEF));
        vq.push_back(mk(6'd9,  16'h0000, 1, 0, 1, 16'h1111));
        vq.push_back(mk(6'd9,  16'h2222, 1, 1, 1, 16'h2222)); // forwarded
        vq.push_back(mk(6'd9,  16'h0000, 1, 0, 1, 16'h2222));
        vq.push_back(mk(6'd5,  16'h0000, 1, 0, 1, 16'hBEEF));
        vq.push_back(mk(6'd63, 16'h1234, 0, 1, 0, 16'hBEEF));
        vq.push_back(mk(6'd63, 16'h0000, 1, 0, 1, 16'h1234));
        vq.push_back(mk(6'd63, 16'h0000, 0, 0, 0, 16'h1234));

        reset_a = 1'b1; idle_a();
        reset_b = 1'b1; addr_b = '0; wd_b = '0; rd_b = 1'b0; wr_b = 1'b0;
        cycle();
        cycle();

        chk("a_reset_ready", 32'(ready_a), 32'd0);
        chk("a_reset_valid", 32'(rvalid_a), 32'd0);
        chk("a_reset_data",  32'(rdata_a), 32'd0);
        chk("b_reset_ready", 32'(ready_b), 32'd1);
        chk("b_reset_valid", 32'(rvalid_b), 32'd0);
        chk("b_reset_data",  32'(rdata_b), 32'd0);

        // Instance B: no clear pass, usable straight after reset.
        reset_b = 1'b0;
        addr_b = 3'd7; wd_b = 8'h7F; wr_b = 1'b1;
        cycle();
        chk("b_ready_after_reset", 32'(ready_b), 32'd1);
        chk("b_write_valid", 32'(rvalid_b), 32'd0);
        wr_b = 1'b0; rd_b = 1'b1;
        cycle();
        chk("b_read_valid", 32'(rvalid_b), 32'd1);
        chk("b_read_data",  32'(rdata_b), 32'h7F);
        rd_b = 1'b0;
        cycle();
        chk("b_hold_valid", 32'(rvalid_b), 32'd0);
        chk("b_hold_data",  32'(rdata_b), 32'h7F);

        // Instance A: clear pass with requests that must be ignored.
        reset_a = 1'b0;
        addr_a = 6'd3; wd_a = 16'hAAAA; wr_a = 1'b1; rd_a = 1'b1;
        count_clear(ncyc, sv);
        idle_a();
        chk("a_clear_cycles", 32'(ncyc), 32'd64);
        chk("a_clear_no_valid", 32'(sv), 32'd0);
        chk("a_clear_data", 32'(rdata_a), 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            addr_a = vq[i].addr; wd_a = vq[i].wdata;
            rd_a = vq[i].rd; wr_a = vq[i].wr;
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(rvalid_a), 32'(vq[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  32'(rdata_a),  32'(vq[i].exp_data));
            chk($sformatf("vec%0d_ready", i), 32'(ready_a),  32'd1);
        end
        idle_a();

        // Reset from IDLE, abort the clear after 20 cycles, reset again.
        reset_a = 1'b1;
        cycle();
        chk("a_rst_idle_ready", 32'(ready_a), 32'd0);
        chk("a_rst_idle_data",  32'(rdata_a), 32'd0);
        reset_a = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("a_midclear_ready", 32'(ready_a), 32'd0);
        reset_a = 1'b1;
        cycle();
        chk("a_rst_mid_ready", 32'(ready_a), 32'd0);
        reset_a = 1'b0;
        count_clear(ncyc, sv);
        chk("a_reclear_cycles", 32'(ncyc), 32'd64);
        chk("a_reclear_no_valid", 32'(sv), 32'd0);

        // Previously written words must now hold the clear value.
        addr_a = 6'd5; rd_a = 1'b1;
        cycle();
        chk("a_cleared5_valid", 32'(rvalid_a), 32'd1);
        chk("a_cleared5_data",  32'(rdata_a), 32'd0);
        addr_a = 6'd63;
        cycle();
        chk("a_cleared63_data", 32'(rdata_a), 32'd0);
        addr_a = 6'd9;
        cycle();
        chk("a_cleared9_data",  32'(rdata_a), 32'd0);
        idle_a();
        cycle();
        chk("a_final_valid", 32'(rvalid_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_data_memory_param
`default_nettype wire
